xoodyak_op_sequencer: RTL and testbench

- Controller that sequences one complete Xoodyak AEAD transaction on the xoodyak_build core.
- Host side: a command handshake plus valid/ready text streams in and out.
- Core side: drives the core's opmode, start and textin, and consumes textout and finished.
- Order per transaction: initialize, nonce, assoc, N crypt/decrypt blocks, optional ratchet, squeeze. Key, nonce and assoc data wire directly to the core and are not handled here.

---
 rtl/xoodyak_pkg.sv | 52 +++++
 rtl/xoodyak_op_sequencer_if.sv | 37 +++
 rtl/xoodyak_phase_timer.sv | 30 +++
 rtl/xoodyak_op_sequencer.sv | 168 ++++++++++++++++
 tb/tb_xoodyak_op_sequencer.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xoodyak_pkg.sv
// Shared Xoodyak definitions: core opmode codes, sequencer phase/state enums and
// the text/tag widths used by the op sequencer and the core wrapper.
package xoodyak_pkg;

  localparam int TEXT_W = 192;
  localparam int TAG_W  = 128;

  localparam logic [3:0] OP_IDLE    = 4'h0;
  localparam logic [3:0] OP_INIT    = 4'h1;
  localparam logic [3:0] OP_NONCE   = 4'h2;
  localparam logic [3:0] OP_ASSOC   = 4'h3;
  localparam logic [3:0] OP_CRYPT   = 4'h4;
  localparam logic [3:0] OP_DECRYPT = 4'h5;
  localparam logic [3:0] OP_SQUEEZE = 4'h6;
  localparam logic [3:0] OP_RATCHET = 4'h7;
  localparam logic [3:0] OP_CONT    = 4'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } state_t;

  typedef enum logic [2:0] {
    PH_INIT,
    PH_NONCE,
    PH_ASSOC,
    PH_CRYPT,
    PH_DECRYPT,
    PH_RATCHET,
    PH_SQUEEZE
  } phase_t;

  function automatic logic [3:0] phase_code(input phase_t ph);
    logic [3:0] code;
    case (ph)
      PH_INIT:    code = OP_INIT;
      PH_NONCE:   code = OP_NONCE;
      PH_ASSOC:   code = OP_ASSOC;
      PH_CRYPT:   code = OP_CRYPT;
      PH_DECRYPT: code = OP_DECRYPT;
      PH_RATCHET: code = OP_RATCHET;
      PH_SQUEEZE: code = OP_SQUEEZE;
      default:    code = OP_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/xoodyak_op_sequencer_if.sv
// Host-side bundle of the op sequencer: command handshake, text in/out streams
// and the tag pulse. The host is the master, the sequencer the slave.
interface xoodyak_op_sequencer_if #(
  parameter int NBLK_W = 6,
  parameter int TEXT_W = xoodyak_pkg::TEXT_W,
  parameter int TAG_W  = xoodyak_pkg::TAG_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_decrypt;
  logic              cmd_ratchet;
  logic [NBLK_W-1:0] cmd_nblocks;
  logic              txt_in_valid;
  logic              txt_in_ready;
  logic [TEXT_W-1:0] txt_in_data;
  logic              txt_out_valid;
  logic              txt_out_ready;
  logic [TEXT_W-1:0] txt_out_data;
  logic              tag_valid;
  logic [TAG_W-1:0]  tag_data;

  modport master (
    output cmd_valid, cmd_decrypt, cmd_ratchet, cmd_nblocks,
    output txt_in_valid, txt_in_data, txt_out_ready,
    input  cmd_ready, txt_in_ready, txt_out_valid, txt_out_data,
    input  tag_valid, tag_data
  );

  modport slave (
    input  cmd_valid, cmd_decrypt, cmd_ratchet, cmd_nblocks,
    input  txt_in_valid, txt_in_data, txt_out_ready,
    output cmd_ready, txt_in_ready, txt_out_valid, txt_out_data,
    output tag_valid, tag_data
  );

endinterface

// File: rtl/xoodyak_phase_timer.sv
// Per-phase watchdog: cleared when a phase is issued, counts while waiting on
// the core, and saturates with expire high on the last allowed cycle.
module xoodyak_phase_timer #(
  parameter int TMO_CYC = 64
) (
  input  logic eph1,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  import xoodyak_pkg::*;

  localparam int CNT_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  logic [CNT_W-1:0] count;

  always_ff @(posedge eph1) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/xoodyak_op_sequencer.sv
// Sequences one Xoodyak AEAD transaction on the core: init, nonce, assoc,
// N crypt/decrypt blocks, optional ratchet, then squeeze to produce the tag.
module xoodyak_op_sequencer #(
  parameter int NBLK_W  = 6,
  parameter int TMO_CYC = 64,
  parameter int TEXT_W  = xoodyak_pkg::TEXT_W
) (
  input  logic                  eph1,
  input  logic                  reset,
  xoodyak_op_sequencer_if.slave host,
  output logic                  busy,
  output logic                  err_timeout,
  output logic                  core_start,
  output logic [3:0]            core_opmode,
  output logic [TEXT_W-1:0]     core_textin,
  input  logic [TEXT_W-1:0]     core_textout,
  input  logic                  core_finished
);
  import xoodyak_pkg::*;

  state_t            state;
  state_t            state_nx;
  phase_t            phase;
  phase_t            after_text;
  logic [NBLK_W-1:0] blk_left;
  logic              decrypt_q;
  logic              ratchet_q;
  logic              cont_q;
  logic              tmr_expire;
  logic              accept;
  logic              text_phase;
  logic              blk_more;
  logic              drain_go;
  logic              in_take;
  logic              wait_done;

  assign accept     = (state == ST_IDLE) && host.cmd_valid;
  assign text_phase = (phase == PH_CRYPT) || (phase == PH_DECRYPT);
  assign blk_more   = (blk_left > NBLK_W'(1));
  assign drain_go   = (state == ST_DRAIN) && host.txt_out_ready;
  assign in_take    = host.txt_in_valid && host.txt_in_ready;
  assign wait_done  = (state == ST_WAIT) && core_finished;
  assign after_text = ratchet_q ? PH_RATCHET : PH_SQUEEZE;

  xoodyak_phase_timer #(.TMO_CYC(TMO_CYC)) u_timer (
    .eph1   (eph1),
    .reset  (reset),
    .clear  (state == ST_ISSUE),
    .enable (state == ST_WAIT),
    .expire (tmr_expire)
  );

  always_ff @(posedge eph1) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // The next block may be fetched in the same cycle the previous output drains.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (host.cmd_valid) state_nx = ST_ISSUE;
      ST_ISSUE: state_nx = ST_WAIT;
      ST_WAIT: begin
        if (core_finished) begin
          if (text_phase) begin
            state_nx = ST_DRAIN;
          end else if (phase == PH_SQUEEZE) begin
            state_nx = ST_DONE;
          end else if ((phase == PH_ASSOC) && (blk_left != '0)) begin
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_ISSUE;
          end
        end else if (tmr_expire) begin
          state_nx = ST_DONE;
        end
      end
      ST_FETCH: if (host.txt_in_valid) state_nx = ST_ISSUE;
      ST_DRAIN: begin
        if (host.txt_out_ready) begin
          if (blk_more && !host.txt_in_valid) begin
            state_nx = ST_FETCH;
          end else begin
            state_nx = ST_ISSUE;
          end
        end
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    host.cmd_ready    = (state == ST_IDLE);
    busy              = (state != ST_IDLE);
    core_start        = (state == ST_ISSUE);
    host.txt_in_ready = (state == ST_FETCH) || (drain_go && blk_more);
    core_opmode       = OP_IDLE;
    if ((state == ST_ISSUE) || (state == ST_WAIT)) begin
      core_opmode = phase_code(phase) | ((cont_q && text_phase) ? OP_CONT : OP_IDLE);
    end
  end

  always_ff @(posedge eph1) begin
    if (!reset) begin
      phase              <= PH_INIT;
      blk_left           <= '0;
      decrypt_q          <= 1'b0;
      ratchet_q          <= 1'b0;
      cont_q             <= 1'b0;
      err_timeout        <= 1'b0;
      core_textin        <= '0;
      host.txt_out_valid <= 1'b0;
      host.txt_out_data  <= '0;
      host.tag_valid     <= 1'b0;
      host.tag_data      <= '0;
    end else begin
      host.tag_valid <= 1'b0;
      if (accept) begin
        phase       <= PH_INIT;
        blk_left    <= host.cmd_nblocks;
        decrypt_q   <= host.cmd_decrypt;
        ratchet_q   <= host.cmd_ratchet;
        cont_q      <= 1'b0;
        err_timeout <= 1'b0;
      end
      if (in_take) begin
        core_textin <= host.txt_in_data;
      end
      if (wait_done) begin
        if (text_phase) begin
          host.txt_out_data  <= core_textout;
          host.txt_out_valid <= 1'b1;
        end else if (phase == PH_SQUEEZE) begin
          host.tag_data  <= core_textout[TAG_W-1:0];
          host.tag_valid <= 1'b1;
        end else begin
          case (phase)
            PH_INIT:    phase <= PH_NONCE;
            PH_NONCE:   phase <= PH_ASSOC;
            PH_ASSOC:   phase <= (blk_left != '0) ? (decrypt_q ? PH_DECRYPT : PH_CRYPT)
                                                  : after_text;
            PH_RATCHET: phase <= PH_SQUEEZE;
            default:    phase <= phase;
          endcase
        end
      end else if ((state == ST_WAIT) && tmr_expire) begin
        err_timeout <= 1'b1;
      end
      // Every drained block marks later crypt blocks as continuations.
      if (drain_go) begin
        host.txt_out_valid <= 1'b0;
        cont_q             <= 1'b1;
        if (blk_left != '0) begin
          blk_left <= blk_left - 1'b1;
        end
        if (!blk_more) begin
          phase <= after_text;
        end
      end
    end
  end

endmodule

// File: tb/tb_xoodyak_op_sequencer.sv
// Directed bench for xoodyak_op_sequencer with a stub core whose result is
// textin XOR 0xAA..AA, finishing a programmable number of cycles after start.
module tb_xoodyak_op_sequencer;

  localparam logic [191:0] PAT = {24{8'hAA}};

  logic         eph1 = 1'b0;
  logic         reset = 1'b0;
  logic         busy;
  logic         err_timeout;
  logic         core_start;
  logic [3:0]   core_opmode;
  logic [191:0] core_textin;
  logic [191:0] core_textout;
  logic         core_finished;

  int           tests = 0;
  int           fails = 0;
  int           stub_delay = 3;
  logic [2:0]   hang_op = 3'd0;
  int           stub_cnt;

  logic [191:0] blks [4];
  logic [191:0] outs [4];
  logic [31:0]  ops;
  int           op_n;
  int           n_out;
  int           tag_cnt;
  int           cycles;
  int           in_idx;
  int           stall_left;
  bit           stall_bad;
  bit           held_set;
  logic [191:0] held;
  logic [127:0] tag_seen;
  logic         busy_at_tag;
  logic         err_at_accept;

  xoodyak_op_sequencer_if #(.NBLK_W(6), .TEXT_W(192), .TAG_W(128)) host_if ();

  xoodyak_op_sequencer #(.NBLK_W(6), .TMO_CYC(64), .TEXT_W(192)) dut (
    .eph1          (eph1),
    .reset         (reset),
    .host          (host_if),
    .busy          (busy),
    .err_timeout   (err_timeout),
    .core_start    (core_start),
    .core_opmode   (core_opmode),
    .core_textin   (core_textin),
    .core_textout  (core_textout),
    .core_finished (core_finished)
  );

  always #5 eph1 = ~eph1;

  // Stub core: result captured at start, finished pulses stub_delay cycles later.
  always @(posedge eph1) begin
    if (!reset) begin
      stub_cnt     <= 0;
      core_textout <= '0;
    end else if (core_start) begin
      stub_cnt     <= (core_opmode[2:0] == hang_op) ? 0 : stub_delay;
      core_textout <= core_textin ^ PAT;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end

  assign core_finished = (stub_cnt == 1);

  task automatic check_output(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] ctrl_vec();
    return {core_start, core_opmode, host_if.txt_out_valid, host_if.tag_valid,
            busy, err_timeout, host_if.txt_in_ready} << 1 | {9'd0, host_if.cmd_ready};
  endfunction

  task automatic check_reset_state(input string tag);
    check_output({tag, "_ctrl"}, 192'(ctrl_vec()), 192'(10'b0000000001));
    check_output({tag, "_textin"}, core_textin, '0);
    check_output({tag, "_outdata"}, host_if.txt_out_data, '0);
    check_output({tag, "_tagdata"}, 192'(host_if.tag_data), '0);
  endtask

  // One full transaction: host feeds blks[], sinks outputs, optionally stalls the first output.
  task automatic apply_stimulus(input bit dec, input bit rat, input int nb, input int stall);
    bit take;
    ops = '0; op_n = 0; n_out = 0; tag_cnt = 0; cycles = 0; in_idx = 0;
    stall_left = stall; stall_bad = 0; held_set = 0; busy_at_tag = 1'b0;
    @(negedge eph1);
    host_if.cmd_decrypt   = dec;
    host_if.cmd_ratchet   = rat;
    host_if.cmd_nblocks   = 6'(nb);
    host_if.cmd_valid     = 1'b1;
    host_if.txt_in_valid  = (nb > 0);
    host_if.txt_in_data   = blks[0];
    host_if.txt_out_ready = 1'b1;
    @(posedge eph1);
    #1;
    host_if.cmd_valid = 1'b0;
    cycles = 1;
    err_at_accept = err_timeout;
    while (host_if.cmd_ready !== 1'b1 && cycles < 2000) begin
      @(negedge eph1);
      host_if.txt_in_valid = (in_idx < nb);
      host_if.txt_in_data  = (in_idx < nb) ? blks[in_idx] : '0;
      if (host_if.txt_out_valid === 1'b1 && stall_left > 0) begin
        host_if.txt_out_ready = 1'b0;
        if (!held_set) begin
          held = host_if.txt_out_data;
          held_set = 1;
        end else if (host_if.txt_out_data !== held) begin
          stall_bad = 1;
        end
        stall_left--;
      end else begin
        host_if.txt_out_ready = 1'b1;
      end
      #1;
      if (core_start === 1'b1) begin
        ops = {ops[27:0], core_opmode};
        op_n++;
        if (host_if.txt_out_ready === 1'b0) stall_bad = 1;
      end
      take = host_if.txt_in_valid && (host_if.txt_in_ready === 1'b1);
      if (host_if.txt_out_valid === 1'b1 && host_if.txt_out_ready) begin
        if (n_out < 4) outs[n_out] = host_if.txt_out_data;
        n_out++;
      end
      if (host_if.tag_valid === 1'b1) begin
        tag_cnt++;
        tag_seen = host_if.tag_data;
        busy_at_tag = busy;
      end
      @(posedge eph1);
      #1;
      cycles++;
      if (take) in_idx++;
    end
    host_if.txt_in_valid = 1'b0;
    check_output("txn_completes", 192'(host_if.cmd_ready), 192'(1'b1));
  endtask

  initial begin
    int k;
    host_if.cmd_valid     = 1'b0;
    host_if.cmd_decrypt   = 1'b0;
    host_if.cmd_ratchet   = 1'b0;
    host_if.cmd_nblocks   = '0;
    host_if.txt_in_valid  = 1'b0;
    host_if.txt_in_data   = '0;
    host_if.txt_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      blks[i] = '0;
      outs[i] = '0;
    end

    reset = 1'b0;
    repeat (3) @(posedge eph1);
    #1;
    check_reset_state("por");
    @(negedge eph1);
    reset = 1'b1;

    $display("[TB] encrypt, 2 blocks, no ratchet");
    stub_delay = 3;
    blks[0] = {24{8'h55}};
    blks[1] = {24{8'h0F}};
    apply_stimulus(1'b0, 1'b0, 2, 0);
    check_output("enc2_opmodes", 192'(ops), 192'(32'h001234C6));
    check_output("enc2_opcount", 192'(op_n), 192'(6));
    check_output("enc2_nout", 192'(n_out), 192'(2));
    check_output("enc2_out0", outs[0], {24{8'hFF}});
    check_output("enc2_out1", outs[1], {24{8'hA5}});
    check_output("enc2_tagcnt", 192'(tag_cnt), 192'(1));
    check_output("enc2_tag", 192'(tag_seen), 192'({16{8'hA5}}));
    check_output("enc2_busy_at_tag", 192'(busy_at_tag), 192'(1'b1));
    check_output("enc2_busy_after", 192'(busy), 192'(1'b0));

    $display("[TB] decrypt, 1 block, ratchet");
    blks[0] = {24{8'h12}};
    apply_stimulus(1'b1, 1'b1, 1, 0);
    check_output("dec1r_opmodes", 192'(ops), 192'(32'h00123576));
    check_output("dec1r_out0", outs[0], {24{8'hB8}});
    check_output("dec1r_tag", 192'(tag_seen), 192'({16{8'hB8}}));

    $display("[TB] zero blocks, 1-cycle core");
    stub_delay = 1;
    apply_stimulus(1'b0, 1'b0, 0, 0);
    check_output("nb0_opmodes", 192'(ops), 192'(32'h00001236));
    check_output("nb0_latency", 192'(cycles), 192'(10));
    check_output("nb0_tagcnt", 192'(tag_cnt), 192'(1));
    check_output("nb0_nout", 192'(n_out), 192'(0));

    $display("[TB] output stalled 20 cycles");
    stub_delay = 2;
    blks[0] = {24{8'h3C}};
    apply_stimulus(1'b0, 1'b0, 1, 20);
    check_output("stall_stable", 192'(stall_bad), 192'(1'b0));
    check_output("stall_served", 192'(stall_left), 192'(0));
    check_output("stall_nout", 192'(n_out), 192'(1));
    check_output("stall_out0", outs[0], {24{8'h96}});

    $display("[TB] core hangs in nonce");
    stub_delay = 1;
    hang_op = 3'd2;
    @(negedge eph1);
    host_if.cmd_decrypt = 1'b0;
    host_if.cmd_ratchet = 1'b0;
    host_if.cmd_nblocks = 6'd0;
    host_if.cmd_valid   = 1'b1;
    @(posedge eph1);
    #1;
    host_if.cmd_valid = 1'b0;
    k = 0;
    while (!(core_start === 1'b1 && core_opmode === 4'h2) && k < 20) begin
      @(negedge eph1);
      #1;
      k++;
    end
    check_output("tmo_nonce_start", 192'(core_start), 192'(1'b1));
    repeat (64) @(posedge eph1);
    #1;
    check_output("tmo_not_yet", 192'(err_timeout), 192'(1'b0));
    @(posedge eph1);
    #1;
    check_output("tmo_set", 192'(err_timeout), 192'(1'b1));
    tag_cnt = 0;
    k = 0;
    while (host_if.cmd_ready !== 1'b1 && k < 10) begin
      @(negedge eph1);
      if (host_if.tag_valid === 1'b1) tag_cnt++;
      @(posedge eph1);
      #1;
      k++;
    end
    check_output("tmo_no_tag", 192'(tag_cnt), 192'(0));
    check_output("tmo_sticky", 192'(err_timeout), 192'(1'b1));
    hang_op = 3'd0;
    apply_stimulus(1'b0, 1'b0, 0, 0);
    check_output("tmo_cleared", 192'(err_at_accept), 192'(1'b0));
    check_output("tmo_next_opmodes", 192'(ops), 192'(32'h00001236));

    $display("[TB] reset during crypt block 1");
    stub_delay = 3;
    @(negedge eph1);
    host_if.cmd_decrypt   = 1'b0;
    host_if.cmd_ratchet   = 1'b0;
    host_if.cmd_nblocks   = 6'd1;
    host_if.cmd_valid     = 1'b1;
    host_if.txt_in_valid  = 1'b1;
    host_if.txt_in_data   = {24{8'hC3}};
    host_if.txt_out_ready = 1'b1;
    @(posedge eph1);
    #1;
    host_if.cmd_valid = 1'b0;
    k = 0;
    while (!(core_start === 1'b1 && core_opmode === 4'h4) && k < 40) begin
      @(negedge eph1);
      #1;
      k++;
    end
    check_output("rst_crypt_start", 192'(core_start), 192'(1'b1));
    @(negedge eph1);
    reset = 1'b0;
    host_if.txt_in_valid = 1'b0;
    @(posedge eph1);
    #1;
    check_reset_state("midrst");
    @(negedge eph1);
    reset = 1'b1;
    repeat (3) @(negedge eph1);
    blks[0] = {24{8'hC3}};
    apply_stimulus(1'b0, 1'b0, 1, 0);
    check_output("rst_next_opmodes", 192'(ops), 192'(32'h00012346));
    check_output("rst_next_out0", outs[0], {24{8'h69}});
    check_output("rst_next_tag", 192'(tag_seen), 192'({16{8'h69}}));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
